// File: rtl/bombsquad_pkg.sv
// Shared game-state codes and timer FSM encoding for the bomb squad game.
// The RAM controller imports the same game-state constants from here.
package bombsquad_pkg;

  localparam int GS_W = 8;

  localparam logic [GS_W-1:0] GS_PLAY       = 8'h10;
  localparam logic [GS_W-1:0] GS_LEVEL_DONE = 8'h20;
  localparam logic [GS_W-1:0] GS_GAME_OVER  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD,
    ST_EXPIRED
  } state_t;

endpackage

// File: rtl/second_tick_gen.sv
// One-second prescaler: pulses tick on every CLK_HZ-th enabled cycle.
// The clear input restarts the count so a fresh level gets a full first second.
module second_tick_gen #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && !clear && (cnt == TERM);

endmodule

// File: rtl/level_countdown_timer.sv
// Per-level bomb countdown: loads a level-dependent start time on play entry,
// counts down once per second, applies strike penalties and flags expiry.
module level_countdown_timer
  import bombsquad_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned BASE_SECONDS    = 120,
  parameter int unsigned STEP_SECONDS    = 10,
  parameter int unsigned MIN_SECONDS     = 20,
  parameter int unsigned PENALTY_SECONDS = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [GS_W-1:0] cur_level,
  input  logic [GS_W-1:0] game_state,
  input  logic            strike,
  output logic [9:0]      time_left,
  output logic            running,
  output logic            tick,
  output logic            expired,
  output logic            boom,
  output state_t          fsm_state
);

  localparam logic [23:0] SPAN = 24'(BASE_SECONDS - MIN_SECONDS);
  localparam logic [10:0] PEN  = 11'(PENALTY_SECONDS);

  state_t          state, state_next;
  logic [GS_W-1:0] gs_q;
  logic [9:0]      time_next;
  logic            expired_next, boom_next;
  logic            sec_tick, play_entry, gs_over, gs_done;
  logic [23:0]     prod;
  logic [9:0]      start;
  logic [10:0]     dec;

  second_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_RUN),
    .clear  (state == ST_LOAD),
    .tick   (sec_tick)
  );

  assign play_entry = (game_state == GS_PLAY) && (gs_q != GS_PLAY);
  assign gs_over    = (game_state == GS_GAME_OVER);
  assign gs_done    = (game_state == GS_LEVEL_DONE);

  // Product at wide width; clamp to the floor before subtracting so it never underflows.
  assign prod  = 24'(cur_level) * 24'(STEP_SECONDS);
  assign start = (prod >= SPAN) ? 10'(MIN_SECONDS) : 10'(24'(BASE_SECONDS) - prod);

  // Strike and tick in one cycle combine into a single saturating subtraction.
  assign dec = (strike ? PEN : 11'd0) + {10'd0, sec_tick};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      gs_q      <= '0;
      time_left <= '0;
      expired   <= 1'b0;
      boom      <= 1'b0;
    end else begin
      state     <= state_next;
      gs_q      <= game_state;
      time_left <= time_next;
      expired   <= expired_next;
      boom      <= boom_next;
    end
  end

  always_comb begin
    state_next   = state;
    time_next    = time_left;
    expired_next = expired;
    boom_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (play_entry) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        time_next    = start;
        expired_next = 1'b0;
        state_next   = ST_RUN;
      end
      ST_RUN: begin
        if (gs_over) begin
          state_next = ST_IDLE;
        end else if (gs_done) begin
          state_next = ST_HOLD;
        end else if (play_entry) begin
          state_next = ST_LOAD;
        end else if (dec != 11'd0) begin
          if (dec >= {1'b0, time_left}) begin
            time_next    = '0;
            expired_next = 1'b1;
            boom_next    = 1'b1;
            state_next   = ST_EXPIRED;
          end else begin
            time_next = time_left - dec[9:0];
          end
        end
      end
      ST_HOLD: begin
        if (gs_over)         state_next = ST_IDLE;
        else if (play_entry) state_next = ST_LOAD;
      end
      ST_EXPIRED: begin
        time_next = '0;
        if (gs_over)         state_next = ST_IDLE;
        else if (play_entry) state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign running   = (state == ST_RUN);
  assign tick      = sec_tick;
  assign fsm_state = state;

endmodule

// File: doc/level_countdown_timer.md
Name: level_countdown_timer

Overview:
- Consumer of `cur_level` from the RAM controller. Produces the per-level bomb countdown.
- Start time shrinks as level rises.
- Counts down one second at a time while the level is in play.
- Applies strike penalties for wrong actions. Freezes when the level is completed. Flags expiry to the game controller and the display/buzzer logic.

Parameters:
- CLK_HZ, 50000000, input clock frequency; sets the 1 s prescaler terminal count.
- BASE_SECONDS, 120, start time at level 0; must be ≤ 1023.
- STEP_SECONDS, 10, seconds removed per level.
- MIN_SECONDS, 20, floor on start time; must be ≥ 1 and ≤ BASE_SECONDS.
- PENALTY_SECONDS, 15, seconds removed per strike.

Ports:
- clk  in  1  on-board clock.
- reset  in  1  asynchronous, active-low reset.
- cur_level  in  8  current level from RAM controller; unsigned.
- game_state  in  8  game controller state code.
- strike  in  1  one-cycle pulse: wrong wire/action.
- time_left  out  10  remaining seconds, unsigned binary.
- running  out  1  high while counting.
- tick  out  1  one-cycle pulse each time a second elapses in RUN.
- expired  out  1  level held high once time reaches 0; cleared on next load or reset.
- boom  out  1  one-cycle pulse on the cycle expiry is entered.

Behaviour:
- Reset (async, active-low):
  - All outputs 0.
  - FSM goes to IDLE.
  - Prescaler cleared.
  - Registered copy of game_state cleared to 0.
- Game state codes:
  - GS_PLAY = 8'h10.
  - GS_LEVEL_DONE = 8'h20.
  - GS_GAME_OVER = 8'h30.
  - All other codes are ignored.
- Play-entry event: game_state == GS_PLAY this cycle and the registered previous game_state != GS_PLAY.
- Start time:
  - `start = BASE_SECONDS - cur_level*STEP_SECONDS`, computed at ≥ 17 bits.
  - If the product ≥ BASE_SECONDS - MIN_SECONDS, start = MIN_SECONDS. No underflow is permitted.
- States:
  - IDLE: time_left holds its value; running = 0. Play-entry → LOAD.
  - LOAD (1 cycle):
    - time_left ← start; expired ← 0; prescaler cleared.
    - Go to RUN.
    - running = 1 from the cycle after LOAD.
  - RUN: prescaler counts to CLK_HZ-1.
    - At terminal count: tick = 1 for that cycle and time_left decrements.
    - strike pulse: time_left -= PENALTY_SECONDS, saturating at 0.
    - strike and tick in the same cycle: subtract PENALTY_SECONDS + 1 as one operation, saturating at 0. tick still pulses.
    - If the next time_left value is 0 → EXPIRED.
    - Entering EXPIRED: boom = 1 for exactly one cycle, expired = 1, running = 0.
    - game_state == GS_LEVEL_DONE → HOLD. Any decrement due in that same cycle is discarded; time_left freezes.
    - game_state == GS_GAME_OVER → IDLE.
    - Priority within a cycle: GAME_OVER > LEVEL_DONE > expiry > decrement.
  - HOLD: running = 0; time_left frozen; strike ignored. Play-entry → LOAD. GS_GAME_OVER → IDLE.
  - EXPIRED: time_left = 0; expired = 1; strike ignored. Play-entry → LOAD. GS_GAME_OVER → IDLE, with expired kept at 1.
- Other timing rules:
  - A play-entry while in RUN (state glitch away and back) reloads via LOAD.
  - cur_level is sampled only in LOAD; changes at other times have no effect.
  - Reset asserted mid-RUN: immediate return to reset values. No boom is generated.

Decomposition:
- Shared package `bombsquad_pkg` holds:
  - GS_PLAY, GS_LEVEL_DONE, GS_GAME_OVER.
  - The 8-bit state-code width.
  - The FSM state enum (IDLE, LOAD, RUN, HOLD, EXPIRED).
  - The RAM controller is to import the same game-state constants.
- Sub-module `second_tick_gen`:
  - Parameter CLK_HZ.
  - Inputs clk, reset, enable, clear.
  - Output tick: one-cycle pulse every CLK_HZ enabled cycles.
  - Counter width = $clog2(CLK_HZ).

Test Plan (all with CLK_HZ=10, BASE=120, STEP=10, MIN=20, PENALTY=15):
- Level 0 load: cur_level=0; game_state 00→10 → time_left=120 one cycle after LOAD; running=1; after 100 cycles time_left=110 with 10 tick pulses.
- Floor: cur_level=12, play-entry → time_left=20 (not 0). cur_level=255 → 20. cur_level=5 → 70.
- Strike saturation and coincidence: time_left=10, strike → 0, boom one cycle, expired=1. Separately, strike on the tick cycle at time_left=40 → 24.
- Natural expiry: start 20; after 200 cycles time_left=0, boom exactly once, expired stays 1, no further ticks; a new play-entry clears expired and reloads.
- Level done: game_state→20 in the same cycle as a tick at time_left=50 → time_left stays 50, running=0; strike ignored; play-entry with cur_level=1 → 110.
- Async reset mid-RUN: reset low between clock edges → all outputs 0 immediately, no boom; after release, play-entry reloads correctly.
